// File: rtl/lcd_text_buffer_if.sv
// Character stream, commit control and packed display words between the text
// source, lcd_text_buffer and the downstream 2x16 LCD controller.
//   ch_valid/ch_data/ch_ready : byte stream handshake (ASCII or control code)
//   commit                    : single-cycle pulse, working -> display copy
//   busy                      : clear in progress or commit pending
//   cursor                    : write position 0..31
//   reg_a..reg_h              : display chars, four per word, char0 in reg_a[31:24]
interface lcd_text_buffer_if;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        commit;
    logic        busy;
    logic [4:0]  cursor;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] reg_c;
    logic [31:0] reg_d;
    logic [31:0] reg_e;
    logic [31:0] reg_f;
    logic [31:0] reg_g;
    logic [31:0] reg_h;

    // Text source / display consumer side.
    modport master (
        output ch_valid, ch_data, commit,
        input  ch_ready, busy, cursor,
        input  reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h
    );

    // Frame buffer side.
    modport slave (
        input  ch_valid, ch_data, commit,
        output ch_ready, busy, cursor,
        output reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h
    );
endinterface

// File: rtl/lcd_text_buffer.sv
// Double-buffered 32-character text frame buffer for the 2x16 LCD controller.
// Bytes are written into a working buffer at the cursor; the display buffer
// (reg_a..reg_h) is only refreshed on commit so the LCD never sees a partial
// frame. Form-feed clears the working buffer over 32 cycles; a commit seen
// during the clear is held pending and performed as the clear finishes.
//
// Ports:
//   lcdclk  : clock
//   resetn  : asynchronous active-low reset
//   bus     : lcd_text_buffer_if.slave (ch_valid/ch_data/ch_ready, commit,
//             busy, cursor, reg_a..reg_h)
//
// Optional feature: define LCD_TEXT_BUFFER_AUTO_COMMIT_EN to add an implicit
// commit on every accepted byte and at the end of every clear.
module lcd_text_buffer #(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter logic [7:0] BAD_CHAR  = 8'h3F
) (
    input  logic                lcdclk,
    input  logic                resetn,
    lcd_text_buffer_if.slave    bus
);

    localparam int unsigned NCHARS   = 32;
    localparam int unsigned CW       = 8;
    localparam int unsigned IW       = 5;
    localparam int unsigned LINE_LEN = 16;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

`ifdef LCD_TEXT_BUFFER_AUTO_COMMIT_EN
    localparam logic AUTO_COMMIT = 1'b1;
`else
    localparam logic AUTO_COMMIT = 1'b0;
`endif

    logic [0:0]    state_q,   state_d;
    logic [IW-1:0] cursor_q,  cursor_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic          pending_q, pending_d;
    logic          ch_ready_q, ch_ready_d;
    logic          busy_q,    busy_d;
    logic [CW-1:0] work_q [NCHARS];
    logic [CW-1:0] work_d [NCHARS];
    logic [CW-1:0] disp_q [NCHARS];
    logic [CW-1:0] disp_d [NCHARS];

    logic          accept;
    logic          copy;
    logic [CW-1:0] byte_in;

    assign byte_in = bus.ch_data;

    // State and buffer registers; reset aborts any clear immediately.
    always_ff @(posedge lcdclk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cursor_q   <= '0;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            ch_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NCHARS; i++) begin
                work_q[i] <= FILL_CHAR;
                disp_q[i] <= FILL_CHAR;
            end
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            ch_ready_q <= ch_ready_d;
            busy_q     <= busy_d;
            for (int i = 0; i < NCHARS; i++) begin
                work_q[i] <= work_d[i];
                disp_q[i] <= disp_d[i];
            end
        end
    end

    // Next-state: byte decode, clear sweep and commit handling.
    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        work_d    = work_q;
        disp_d    = disp_q;
        accept    = 1'b0;
        copy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ch_ready_q is low for the first cycle out of reset.
                accept = bus.ch_valid & ch_ready_q;
                if (accept) begin
                    if (byte_in >= 8'h20 && byte_in <= 8'h7E) begin
                        work_d[cursor_q] = byte_in;
                        cursor_d         = cursor_q + IW'(1);
                    end else begin
                        case (byte_in)
                            CH_LF: cursor_d = (cursor_q < IW'(LINE_LEN)) ? IW'(LINE_LEN) : '0;
                            CH_CR: cursor_d = (cursor_q < IW'(LINE_LEN)) ? '0 : IW'(LINE_LEN);
                            CH_BS: cursor_d = (cursor_q == '0) ? '0 : cursor_q - IW'(1);
                            CH_FF: begin
                                state_d = ST_CLEAR;
                                idx_d   = '0;
                            end
                            default: begin
                                work_d[cursor_q] = BAD_CHAR;
                                cursor_d         = cursor_q + IW'(1);
                            end
                        endcase
                    end
                end
                copy = bus.commit | (AUTO_COMMIT & accept);
            end

            ST_CLEAR: begin
                work_d[idx_q] = FILL_CHAR;
                idx_d         = idx_q + IW'(1);
                if (bus.commit) begin
                    pending_d = 1'b1;
                end
                // Final sweep cycle: the copy sees the fully blanked frame.
                if (idx_q == IW'(NCHARS - 1)) begin
                    state_d   = ST_IDLE;
                    cursor_d  = '0;
                    idx_d     = '0;
                    copy      = pending_q | bus.commit | AUTO_COMMIT;
                    pending_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Display captures next-state working so a same-cycle byte is included.
        if (copy) begin
            disp_d = work_d;
        end

        ch_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d == ST_CLEAR) | pending_d;
    end

    assign bus.ch_ready = ch_ready_q;
    assign bus.busy     = busy_q;
    assign bus.cursor   = cursor_q;
    assign bus.reg_a    = {disp_q[0],  disp_q[1],  disp_q[2],  disp_q[3]};
    assign bus.reg_b    = {disp_q[4],  disp_q[5],  disp_q[6],  disp_q[7]};
    assign bus.reg_c    = {disp_q[8],  disp_q[9],  disp_q[10], disp_q[11]};
    assign bus.reg_d    = {disp_q[12], disp_q[13], disp_q[14], disp_q[15]};
    assign bus.reg_e    = {disp_q[16], disp_q[17], disp_q[18], disp_q[19]};
    assign bus.reg_f    = {disp_q[20], disp_q[21], disp_q[22], disp_q[23]};
    assign bus.reg_g    = {disp_q[24], disp_q[25], disp_q[26], disp_q[27]};
    assign bus.reg_h    = {disp_q[28], disp_q[29], disp_q[30], disp_q[31]};

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed + randomized bench for lcd_text_buffer against a transaction-level
// model of the working/display buffers and cursor.
module tb_lcd_text_buffer;

    logic lcdclk = 1'b0;
    logic resetn = 1'b0;

    lcd_text_buffer_if ifc ();

    lcd_text_buffer dut (
        .lcdclk (lcdclk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    always #5 lcdclk = ~lcdclk;

`ifdef LCD_TEXT_BUFFER_AUTO_COMMIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [7:0] work_m [32];
    logic [7:0] disp_m [32];
    int         cur_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            work_m[i] = 8'h20;
            disp_m[i] = 8'h20;
        end
        cur_m = 0;
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < 32; i++) disp_m[i] = work_m[i];
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            work_m[cur_m] = b;
            cur_m = (cur_m + 1) % 32;
        end else if (b == 8'h0A) begin
            cur_m = (cur_m < 16) ? 16 : 0;
        end else if (b == 8'h0D) begin
            cur_m = (cur_m < 16) ? 0 : 16;
        end else if (b == 8'h08) begin
            cur_m = (cur_m > 0) ? cur_m - 1 : 0;
        end else if (b == 8'h0C) begin
            for (int i = 0; i < 32; i++) work_m[i] = 8'h20;
            cur_m = 0;
        end else begin
            work_m[cur_m] = 8'h3F;
            cur_m = (cur_m + 1) % 32;
        end
    endfunction

    function automatic logic [31:0] exp_word(input int k);
        return {disp_m[4*k], disp_m[4*k+1], disp_m[4*k+2], disp_m[4*k+3]};
    endfunction

    function automatic logic [31:0] dut_word(input int k);
        case (k)
            0: return ifc.reg_a;
            1: return ifc.reg_b;
            2: return ifc.reg_c;
            3: return ifc.reg_d;
            4: return ifc.reg_e;
            5: return ifc.reg_f;
            6: return ifc.reg_g;
            default: return ifc.reg_h;
        endcase
    endfunction

    // Called at a negedge; leaves at a negedge with everything released.
    task automatic do_reset();
        resetn = 1'b0;
        ifc.ch_valid = 1'b0;
        ifc.commit = 1'b0;
        ifc.ch_data = 8'h00;
        model_reset();
        repeat (2) @(negedge lcdclk);
        chk("rst_ready", 32'(ifc.ch_ready), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        resetn = 1'b1;
        @(negedge lcdclk);
        chk("rst_release_ready", 32'(ifc.ch_ready), 32'd1);
    endtask

    // One byte, optionally with commit in the same cycle; waits for ch_ready.
    task automatic send(input logic [7:0] b, input bit cm);
        int w = 0;
        while (ifc.ch_ready !== 1'b1 && w < 200) begin
            @(negedge lcdclk);
            w++;
        end
        chk("send_ready", 32'(ifc.ch_ready), 32'd1);
        ifc.ch_valid = 1'b1;
        ifc.ch_data  = b;
        ifc.commit   = cm;
        @(negedge lcdclk);
        ifc.ch_valid = 1'b0;
        ifc.commit   = 1'b0;
        ifc.ch_data  = 8'($urandom);
        model_byte(b);
        if (cm || AUTO) model_commit();
    endtask

    task automatic pulse_commit();
        ifc.commit = 1'b1;
        @(negedge lcdclk);
        ifc.commit = 1'b0;
        model_commit();
    endtask

    task automatic check_all(input string tag);
        int w = 0;
        while (ifc.busy !== 1'b0 && w < 200) begin
            @(negedge lcdclk);
            w++;
        end
        chk($sformatf("%s_busy", tag), 32'(ifc.busy), 32'd0);
        chk($sformatf("%s_cursor", tag), 32'(ifc.cursor), 32'(cur_m));
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_reg%0d", tag, k), dut_word(k), exp_word(k));
    endtask

    initial begin
        int cnt;
        logic [7:0] b;
        bit cm;
        logic [7:0] hello [5];
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

        ifc.ch_valid = 1'b0;
        ifc.ch_data  = 8'h00;
        ifc.commit   = 1'b0;
        @(negedge lcdclk);

        // Reset state.
        do_reset();
        check_all("reset");

        // HELLO stream then commit.
        for (int i = 0; i < 5; i++) send(hello[i], 1'b0);
        pulse_commit();
        chk("hello_reg_a", ifc.reg_a, 32'h48454C4C);
        chk("hello_reg_b", ifc.reg_b, 32'h4F202020);
        chk("hello_reg_h", ifc.reg_h, 32'h20202020);
        check_all("hello");

        // Line feed moves to line 2.
        do_reset();
        send(8'h41, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h42, 1'b0);
        pulse_commit();
        chk("lf_char0", 32'(ifc.reg_a[31:24]), 32'h41);
        chk("lf_char16", 32'(ifc.reg_e[31:24]), 32'h42);
        chk("lf_cursor", 32'(ifc.cursor), 32'd17);
        check_all("lf");

        // Cursor wrap 31 -> 0.
        do_reset();
        for (int i = 0; i < 32; i++) send(8'h5A, 1'b0);
        chk("wrap_cursor0", 32'(ifc.cursor), 32'd0);
        send(8'h51, 1'b0);
        pulse_commit();
        chk("wrap_reg_a", ifc.reg_a, 32'h515A5A5A);
        chk("wrap_cursor1", 32'(ifc.cursor), 32'd1);
        check_all("wrap");

        // Form feed with a commit landing 3 cycles into the clear.
        do_reset();
        for (int i = 0; i < 32; i++) send(8'($urandom_range(33, 126)), 1'b0);
        pulse_commit();
        check_all("prefill");
        send(8'h0C, 1'b0);
        cnt = 0;
        while (ifc.ch_ready === 1'b0 && cnt < 100) begin
            ifc.commit = (cnt == 3);
            if (cnt == 10) chk("clear_busy_mid", 32'(ifc.busy), 32'd1);
            @(negedge lcdclk);
            cnt++;
        end
        ifc.commit = 1'b0;
        model_commit();
        chk("clear_ready_low_cycles", 32'(cnt), 32'd32);
        chk("clear_busy_end", 32'(ifc.busy), 32'd0);
        chk("clear_reg_a", ifc.reg_a, 32'h20202020);
        check_all("clear");

        // Backspace saturation and unrecognised control code.
        do_reset();
        send(8'h08, 1'b0);
        chk("bs_at_zero", 32'(ifc.cursor), 32'd0);
        send(8'h01, 1'b0);
        chk("bad_cursor", 32'(ifc.cursor), 32'd1);
        pulse_commit();
        chk("bad_char0", 32'(ifc.reg_a[31:24]), 32'h3F);
        check_all("bad");

        // Reset during clear at idx 10.
        send(8'h0C, 1'b0);
        repeat (10) @(negedge lcdclk);
        chk("midclear_busy", 32'(ifc.busy), 32'd1);
        resetn = 1'b0;
        model_reset();
        #1;
        chk("midclear_rst_ready", 32'(ifc.ch_ready), 32'd0);
        chk("midclear_rst_busy", 32'(ifc.busy), 32'd0);
        chk("midclear_rst_cursor", 32'(ifc.cursor), 32'd0);
        chk("midclear_rst_reg_a", ifc.reg_a, 32'h20202020);
        @(negedge lcdclk);
        resetn = 1'b1;
        @(negedge lcdclk);
        chk("midclear_release_ready", 32'(ifc.ch_ready), 32'd1);
        check_all("midclear");

        // Randomized stream with same-cycle commits, gaps and periodic checks.
        for (int n = 0; n < 300; n++) begin
            cnt = $urandom_range(0, 99);
            if (cnt < 70)      b = 8'($urandom_range(32, 126));
            else if (cnt < 78) b = 8'h0A;
            else if (cnt < 84) b = 8'h0D;
            else if (cnt < 91) b = 8'h08;
            else if (cnt < 93) b = 8'h0C;
            else               b = 8'($urandom_range(0, 255));
            cm = ($urandom_range(0, 9) == 0) && (b != 8'h0C);
            send(b, cm);
            if ($urandom_range(0, 3) == 0) @(negedge lcdclk);
            if (cm) check_all($sformatf("rnd_cm%0d", n));
            if (n % 25 == 24) begin
                pulse_commit();
                check_all($sformatf("rnd_pc%0d", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- Character frame buffer feeding the 2x16 text LCD controller; sits directly upstream of it.
- Accepts a byte stream of ASCII characters and control codes over a valid/ready handshake.
- Maintains a 32-character working buffer and a display buffer, plus a write cursor.
- The display buffer is presented packed as eight 32-bit words, reg_a..reg_h, consumed by the LCD controller.
- The display buffer changes only on commit, so the LCD never shows a half-written frame.

Parameters:
- FILL_CHAR, 8'h20, byte written by reset and by form-feed clear.
- BAD_CHAR, 8'h3F, byte stored in place of an unrecognised non-printable code.

Ports:
- lcdclk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- ch_valid  in  1  ch_data valid
- ch_data  in  8  ASCII byte or control code
- ch_ready  out  1  block can accept a byte this cycle
- commit  in  1  single-cycle pulse: copy working buffer to display buffer
- busy  out  1  clear in progress or commit pending
- cursor  out  5  current write position, 0..31 (0..15 line 1, 16..31 line 2)
- reg_a..reg_h  out  32 each  display chars; reg_a[31:24]=char0, reg_a[7:0]=char3, ..., reg_d[7:0]=char15, reg_e[31:24]=char16, ..., reg_h[7:0]=char31

Behaviour:
- Reset (asynchronous, resetn low):
  - Both buffers = FILL_CHAR in every byte (reg_a..reg_h = 32'h20202020).
  - cursor = 0, state = IDLE, ch_ready = 0 while resetn is low, busy = 0, pending = 0.
- Reset mid-clear or mid-anything aborts immediately to the reset values above.
- State IDLE: ch_ready = 1. A byte is accepted on a lcdclk edge with ch_valid & ch_ready.
- Accepted byte decode (one byte per cycle, zero bubble):
  - 0x20..0x7E: working[cursor] <= byte; cursor <= cursor+1, wrapping 31 -> 0.
  - 0x0A (LF): cursor <= 16 if cursor < 16, else 0.
  - 0x0D (CR): cursor <= 0 if cursor < 16, else 16.
  - 0x08 (BS): cursor <= cursor-1, saturating at 0; no buffer write.
  - 0x0C (FF): go to CLEAR; ch_ready falls the next cycle.
  - Any other byte: working[cursor] <= BAD_CHAR; cursor advances as for a printable byte.
- State CLEAR:
  - ch_ready = 0, busy = 1.
  - Writes FILL_CHAR to working[idx] for idx = 0..31, one byte per cycle (exactly 32 cycles).
  - After idx 31: cursor <= 0, return to IDLE; ch_ready = 1 on the following cycle.
- Commit:
  - In IDLE, a commit pulse copies the working buffer to the display buffer at that edge.
  - If a byte is accepted in the same cycle, the copy includes that byte's write (display <= next-state working).
  - reg_* update one cycle after the commit edge. The cursor is not affected.
- Commit during CLEAR: set pending; busy stays 1. Perform the copy on the cycle CLEAR returns to IDLE, so the display shows a blank frame. Then pending = 0.
- Multiple commits while pending collapse into one.
- busy = (state == CLEAR) | pending.
- ch_data is ignored when ch_valid = 0 or ch_ready = 0; no byte is lost or duplicated.
- reg_* are registered outputs, stable between commits, and glitch-free for the asynchronous LCD controller decoder.

Optional Feature:
- Macro: LCD_TEXT_BUFFER_AUTO_COMMIT_EN
- Defined:
  - An implicit commit accompanies every accepted byte and the end of every CLEAR.
  - The display then tracks the working buffer with one cycle of latency; the commit pin remains functional.
- Undefined: the display updates only on an explicit commit pulse (or a pending commit after CLEAR).

Test Plan:
- Reset, then stream "HELLO" (48 45 4C 4C 4F) and pulse commit -> reg_a = 32'h48454C4C, reg_b = 32'h4F202020, cursor = 5, reg_e..reg_h = 32'h20202020.
- Write 'A', send 0x0A, write 'B', commit -> char0 = 0x41, char16 = 0x42 (reg_e[31:24] = 8'h42), cursor = 17.
- Write 32 'Z' then one 'Q' -> cursor goes 31 -> 0, working char0 = 0x51; after commit reg_a = 32'h515A5A5A, cursor = 1.
- Fill the buffer, send 0x0C, pulse commit 3 cycles later -> ch_ready = 0 for 32 cycles, busy = 1 until pending commit completes, all reg_* = 32'h20202020, cursor = 0.
- Send 0x08 at cursor 0 -> cursor stays 0. Send 0x01 -> char = 0x3F stored, cursor + 1.
- Assert resetn low during CLEAR at idx 10 -> all outputs return to reset values immediately; after release, ch_ready = 1 on the first edge.
